// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage pipeline: stall/flush strobes, E-stage
// forwarding selects, memory-wait watchdog and saturating performance counters.
module hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32,
    parameter int TIMEOUT        = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_e,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_e,
    input  logic [REG_ADDR_WIDTH-1:0] rd_e,
    input  logic [REG_ADDR_WIDTH-1:0] rd_m,
    input  logic [REG_ADDR_WIDTH-1:0] rd_w,
    input  logic                      mem_read_e,
    input  logic                      reg_write_m,
    input  logic                      reg_write_w,
    input  logic                      branch_taken_e,
    input  logic                      mem_req_m,
    input  logic                      mem_ready,
    output logic                      stall_f,
    output logic                      stall_d,
    output logic                      stall_e,
    output logic                      stall_m,
    output logic                      flush_d,
    output logic                      flush_e,
    output logic [1:0]                fwd_a_e,
    output logic [1:0]                fwd_b_e,
    output logic                      mem_timeout,
    output logic [CNT_WIDTH-1:0]      stall_cycles,
    output logic [CNT_WIDTH-1:0]      flush_count
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
    logic              timeout_next;
    logic              mem_stall, load_use, branch_sel;

    // M result wins over W result; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_WIDTH-1:0] rs,
        input logic [REG_ADDR_WIDTH-1:0] dst_m,
        input logic [REG_ADDR_WIDTH-1:0] dst_w,
        input logic                      wr_m,
        input logic                      wr_w
    );
        if (wr_m && dst_m != '0 && dst_m == rs)      return 2'b10;
        else if (wr_w && dst_w != '0 && dst_w == rs) return 2'b01;
        else                                         return 2'b00;
    endfunction

    assign mem_stall = mem_req_m && !mem_ready;
    assign load_use  = mem_read_e && rd_e != '0 && (rd_e == rs1_d || rd_e == rs2_d);

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        stall_e    = 1'b0;
        stall_m    = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        branch_sel = 1'b0;
        fwd_a_e    = 2'b00;
        fwd_b_e    = 2'b00;
        if (rst_n) begin
            fwd_a_e = fwd_sel(rs1_e, rd_m, rd_w, reg_write_m, reg_write_w);
            fwd_b_e = fwd_sel(rs2_e, rd_m, rd_w, reg_write_m, reg_write_w);
            if (mem_stall) begin
                // A pending branch simply waits in E until memory answers.
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
            end else if (branch_taken_e) begin
                flush_d    = 1'b1;
                flush_e    = 1'b1;
                branch_sel = 1'b1;
            end else if (load_use) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    // wait_cnt counts MEM_WAIT cycles including the entry edge, so it equals
    // TIMEOUT-1 during the TIMEOUT-th consecutive stalled cycle.
    always_comb begin
        state_next    = state;
        wait_cnt_next = '0;
        timeout_next  = mem_timeout;
        unique case (state)
            RUN: begin
                if (mem_stall) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_next = RUN;
                end else begin
                    wait_cnt_next = (wait_cnt == WAIT_W'(TIMEOUT)) ? wait_cnt
                                                                   : wait_cnt + WAIT_W'(1);
                    if (wait_cnt == WAIT_W'(TIMEOUT - 1)) timeout_next = 1'b1;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // NOTE: state elements use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            wait_cnt     <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state       <= state_next;
            wait_cnt    <= wait_cnt_next;
            mem_timeout <= timeout_next;
            if (stall_f && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_WIDTH'(1);
            if (branch_sel && !(&flush_count)) flush_count <= flush_count + CNT_WIDTH'(1);
        end
    end

endmodule
